// File: rtl/ercm_err_stat.sv
// ercm_err_stat: error-distance statistics for an approximate 8x8 multiplier over an N-sample campaign.
// Define ERCM_ERR_SQ_EN to add err_sq_sum, the running sum of squared error distance.
module ercm_err_stat #(
  parameter int SMP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SMP_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic [15:0]      prod_apx,
  output logic             busy,
  output logic             done,
  output logic [SMP_W-1:0] sample_cnt,
  output logic [SMP_W-1:0] err_cnt,
  output logic [31:0]      err_sum,
  output logic [15:0]      err_max
`ifdef ERCM_ERR_SQ_EN
  , output logic [47:0]    err_sq_sum
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [SMP_W-1:0] n_q, sample_cnt_q, err_cnt_q;
  logic [31:0] err_sum_q;
  logic [15:0] err_max_q, apx_q, ed_q, exact;
  logic [7:0] a_q, b_q;
  logic v0_q, v1_q, xfer, clr;
  logic [32:0] sum_ext;
  assign xfer = in_valid & in_ready;
  assign clr = (state_q == IDLE) & start;
  assign exact = a_q * b_q;
  assign sum_ext = {1'b0, err_sum_q} + {17'b0, ed_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (num_samples == '0) ? DONE : RUN;
      RUN:   if (xfer && sample_cnt_q == n_q - 1'b1) state_d = DRAIN;
      DRAIN: if (!v0_q && !v1_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == RUN;
    busy = (state_q == RUN) | (state_q == DRAIN);
    done = state_q == DONE;
  end
  // Stage 0 captures the accepted sample, stage 1 holds its error distance, then statistics fold it in.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      apx_q <= '0;
      ed_q <= '0;
      n_q <= '0;
      sample_cnt_q <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
    end else begin
      v0_q <= xfer;
      v1_q <= v0_q;
      if (xfer) begin
        a_q <= op_a;
        b_q <= op_b;
        apx_q <= prod_apx;
      end
      if (v0_q) ed_q <= (exact >= apx_q) ? exact - apx_q : apx_q - exact;
      if (clr) begin
        n_q <= num_samples;
        sample_cnt_q <= '0;
        err_cnt_q <= '0;
        err_sum_q <= '0;
        err_max_q <= '0;
      end else begin
        if (xfer) sample_cnt_q <= sample_cnt_q + 1'b1;
        if (v1_q) begin
          err_cnt_q <= err_cnt_q + SMP_W'(ed_q != '0);
          err_sum_q <= sum_ext[32] ? '1 : sum_ext[31:0];
          err_max_q <= (ed_q > err_max_q) ? ed_q : err_max_q;
        end
      end
    end
`ifdef ERCM_ERR_SQ_EN
  logic [47:0] err_sq_sum_q;
  logic [31:0] ed_sq;
  assign ed_sq = ed_q * ed_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_sq_sum_q <= '0;
    else if (clr) err_sq_sum_q <= '0;
    else if (v1_q) err_sq_sum_q <= err_sq_sum_q + {16'b0, ed_sq};
  assign err_sq_sum = err_sq_sum_q;
`endif
  assign sample_cnt = sample_cnt_q;
  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
endmodule

// File: tb/tb_ercm_err_stat.sv
// tb_ercm_err_stat: randomized self-checking bench for ercm_err_stat against an arithmetic reference model.
module tb_ercm_err_stat;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [15:0] num_samples = 0, prod_apx = 0;
  logic [7:0] op_a = 0, op_b = 0;
  logic in_ready, busy, done;
  logic [15:0] sample_cnt, err_cnt, err_max;
  logic [31:0] err_sum;
`ifdef ERCM_ERR_SQ_EN
  logic [47:0] err_sq_sum;
`endif
  logic [79:0] st, exp_st;
  logic [47:0] exp_sq;
  logic [7:0] qa[$], qb[$];
  logic [15:0] qp[$];
  int nvec = 0, nerr = 0;
  int lat;
  bit rdy_after, dpost, busy_seen;

  ercm_err_stat dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .prod_apx(prod_apx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max)
`ifdef ERCM_ERR_SQ_EN
    , .err_sq_sum(err_sq_sum)
`endif
  );

  assign st = {sample_cnt, err_cnt, err_sum, err_max};
  always #5 clk = ~clk;

  task automatic clear_q();
    qa.delete(); qb.delete(); qp.delete();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    qa.push_back(a); qb.push_back(b); qp.push_back(p);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a, b;
      int e;
      a = 8'($urandom); b = 8'($urandom);
      e = int'(a) * int'(b);
      case ($urandom_range(0, 2))
        0: push(a, b, 16'(e));
        1: push(a, b, 16'(e + int'($urandom_range(0, 64)) - 32));
        default: push(a, b, 16'($urandom));
      endcase
    end
  endtask

  task automatic model();
    longint ec = 0, es = 0, em = 0, eq = 0;
    foreach (qa[i]) begin
      longint ed;
      ed = longint'(qa[i]) * longint'(qb[i]) - longint'(qp[i]);
      if (ed < 0) ed = -ed;
      if (ed != 0) ec++;
      es += ed;
      eq += ed * ed;
      if (ed > em) em = ed;
    end
    exp_st = {16'(qa.size()), 16'(ec), 32'(es), 16'(em)};
    exp_sq = 48'(eq);
  endtask

  // mode 0: valid every cycle; 1: valid every other cycle plus stray start pulses; 2: random valid
  task automatic run_camp(input int mode);
    int idx = 0, cyc = 0;
    bit x;
    num_samples = 16'(qa.size());
    start = 1;
    busy_seen = 0;
    @(posedge clk); #1;
    start = 0;
    while (idx < qa.size() && cyc < 400) begin
      busy_seen |= busy;
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (mode == 1) begin
        start = (cyc % 3 == 1);
        num_samples = 16'd2;
      end
      op_a = qa[idx]; op_b = qb[idx]; prod_apx = qp[idx];
      x = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (x) idx++;
    end
    in_valid = 0; start = 0;
    rdy_after = in_ready;
    lat = 0;
    while (!done && lat < 20) begin
      busy_seen |= busy;
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    dpost = done;
  endtask

  task automatic test_reset();
    #12;
    nvec++; if ({in_ready, busy, done} !== 3'b000) begin nerr++; $display("FAIL reset_ctl: got %b expected 000", {in_ready, busy, done}); end
    nvec++; if (st !== 80'h0) begin nerr++; $display("FAIL reset_stats: got %h expected 0", st); end
    rst_n = 1;
    in_valid = 1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 0;
    nvec++; if ({in_ready, sample_cnt} !== 17'h0) begin nerr++; $display("FAIL idle_valid: got %h expected 0", {in_ready, sample_cnt}); end
  endtask

  task automatic test_exact();
    clear_q(); push(8'd255, 8'd255, 16'hFE01); model();
    run_camp(0);
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL exact_latency: got %0d expected 3", lat); end
    nvec++; if (dpost !== 1'b0) begin nerr++; $display("FAIL exact_done_width: got %b expected 0", dpost); end
    nvec++; if (st !== {16'd1, 16'd0, 32'd0, 16'd0}) begin nerr++; $display("FAIL exact_stats: got %h expected %h", st, {16'd1, 16'd0, 32'd0, 16'd0}); end
    nvec++; if (busy_seen !== 1'b1) begin nerr++; $display("FAIL exact_busy: got %b expected 1", busy_seen); end
  endtask

  task automatic test_errors();
    clear_q(); push(8'd3, 8'd3, 16'd7); push(8'd10, 8'd10, 16'd96); push(8'd255, 8'd255, 16'hFC00); model();
    @(posedge clk); #1;
    run_camp(0);
    nvec++; if (st !== {16'd3, 16'd3, 32'd519, 16'd513}) begin nerr++; $display("FAIL errors_known: got %h expected %h", st, {16'd3, 16'd3, 32'd519, 16'd513}); end
    nvec++; if (st !== exp_st) begin nerr++; $display("FAIL errors_model: got %h expected %h", st, exp_st); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL errors_latency: got %0d expected 3", lat); end
`ifdef ERCM_ERR_SQ_EN
    nvec++; if (err_sq_sum !== 48'd263189) begin nerr++; $display("FAIL errors_sq: got %0d expected 263189", err_sq_sum); end
`endif
  endtask

  task automatic test_zero();
    clear_q();
    @(posedge clk); #1;
    run_camp(0);
    nvec++; if (lat !== 0) begin nerr++; $display("FAIL zero_latency: got %0d expected 0", lat); end
    nvec++; if (busy_seen !== 1'b0) begin nerr++; $display("FAIL zero_busy: got %b expected 0", busy_seen); end
    nvec++; if (st !== 80'h0) begin nerr++; $display("FAIL zero_stats: got %h expected 0", st); end
    nvec++; if (dpost !== 1'b0) begin nerr++; $display("FAIL zero_done_width: got %b expected 0", dpost); end
  endtask

  task automatic test_throttle();
    clear_q(); push_rand(4); model();
    @(posedge clk); #1;
    run_camp(1);
    nvec++; if (rdy_after !== 1'b0) begin nerr++; $display("FAIL throttle_ready: got %b expected 0", rdy_after); end
    nvec++; if (st !== exp_st) begin nerr++; $display("FAIL throttle_stats: got %h expected %h", st, exp_st); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL throttle_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_abort();
    int dones = 0;
    clear_q(); push_rand(5);
    @(posedge clk); #1;
    num_samples = 16'd5; start = 1;
    @(posedge clk); #1;
    start = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      op_a = qa[i]; op_b = qb[i]; prod_apx = qp[i];
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst_n = 0;
    #1;
    nvec++; if ({in_ready, busy, done, st} !== 83'h0) begin nerr++; $display("FAIL abort_outputs: got %h expected 0", {in_ready, busy, done, st}); end
    repeat (2) begin @(posedge clk); #1; dones += done; end
    rst_n = 1;
    repeat (5) begin @(posedge clk); #1; dones += done; end
    nvec++; if (dones !== 0) begin nerr++; $display("FAIL abort_done: got %0d expected 0", dones); end
    clear_q(); push_rand(1); model();
    run_camp(0);
    nvec++; if (st !== exp_st) begin nerr++; $display("FAIL abort_restart: got %h expected %h", st, exp_st); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL abort_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_back_to_back();
    clear_q(); push_rand(2); model();
    @(posedge clk); #1;
    run_camp(0);
    nvec++; if (st !== exp_st) begin nerr++; $display("FAIL b2b_first: got %h expected %h", st, exp_st); end
    clear_q(); push(8'd200, 8'd7, 16'd1234); model();
    run_camp(2);
    nvec++; if (st !== exp_st) begin nerr++; $display("FAIL b2b_second: got %h expected %h", st, exp_st); end
`ifdef ERCM_ERR_SQ_EN
    nvec++; if (err_sq_sum !== exp_sq) begin nerr++; $display("FAIL b2b_sq: got %0d expected %0d", err_sq_sum, exp_sq); end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 6; c++) begin
      clear_q(); push_rand(int'($urandom_range(1, 10))); model();
      run_camp(2);
      nvec++; if (st !== exp_st) begin nerr++; $display("FAIL rand%0d_stats: got %h expected %h", c, st, exp_st); end
      nvec++; if ({lat, dpost} !== {32'd3, 1'b0}) begin nerr++; $display("FAIL rand%0d_timing: got lat=%0d done_after=%b expected lat=3 done_after=0", c, lat, dpost); end
`ifdef ERCM_ERR_SQ_EN
      nvec++; if (err_sq_sum !== exp_sq) begin nerr++; $display("FAIL rand%0d_sq: got %0d expected %0d", c, err_sq_sum, exp_sq); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_errors();
    test_zero();
    test_throttle();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
